hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Control end of the pipeline-register interface: drives stall/enable and clr (flush) inputs of the
//  IF/ID and ID/EX registers, plus EX-stage forwarding selects. Detects load-use hazards in ID vs EX
//  and holds F/D for LOAD_STALL_CYCLES while feeding bubbles into EX. Flushes D/E on taken branch/jump.
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..15)
//  CNT_W              32  width of the performance counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  Rs1D, Rs2D   in   5      source regs of instruction in ID
//  Rs1E, Rs2E   in   5      source regs of instruction in EX
//  RdE          in   5      dest reg in EX
//  ResultSrcE   in   2      2'b01 = load in EX
//  RegWriteE    in   1      EX instruction writes RF
//  RdM, RdW     in   5      dest regs in MEM / WB
//  RegWriteM    in   1      MEM instruction writes RF
//  RegWriteW    in   1      WB instruction writes RF
//  PCSrcE       in   1      branch/jump taken, resolved in EX
//  StallF       out  1      hold PC
//  StallD       out  1      hold IF/ID (en = ~StallD)
//  FlushD       out  1      clr of IF/ID
//  FlushE       out  1      clr of ID/EX
//  ForwardAE    out  2      00 RD1E, 10 ALUResultM, 01 ResultW
//  ForwardBE    out  2      same encoding for RD2E
//  stall_cnt    out  CNT_W  total stall cycles
//  flush_cnt    out  CNT_W  total taken-branch flushes
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state<=RUN, bubble counter<=0, stall_cnt<=0, flush_cnt<=0. While rst high
//    all stall/flush outputs and ForwardAE/BE are forced 0.
//  - lwHit = RegWriteE & (ResultSrcE==2'b01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D). Combinational.
//  - FSM: RUN, STALL.
//    RUN : lwHit & ~PCSrcE -> StallF=StallD=1, FlushE=1 same cycle (zero latency);
//          if LOAD_STALL_CYCLES>1 go STALL with cnt<=LOAD_STALL_CYCLES-2, else stay RUN.
//    STALL: StallF=StallD=FlushE=1; cnt==0 -> RUN next cycle, else cnt<=cnt-1.
//          Total held cycles per hazard = exactly LOAD_STALL_CYCLES.
//  - PCSrcE=1 (any state): FlushD=1, FlushE=1, StallF=StallD=0, next state RUN, cnt<=0.
//    PCSrcE overrides lwHit and aborts an in-progress STALL.
//  - Forwarding (combinational, every state): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E;
//    else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. MEM beats WB. ForwardBE same with Rs2E.
//    x0 never forwarded.
//  - stall_cnt +1 per cycle with StallD=1; flush_cnt +1 per cycle with PCSrcE=1 and rst=0.
//    Both saturate at all-ones (no wrap).
//  - rst asserted mid-STALL: next cycle RUN, no residual stall.
// TESTING
//  1 lw x5 in EX (RdE=5,ResultSrcE=01,RegWriteE=1), Rs1D=5, N=1 -> one cycle StallF=StallD=FlushE=1; stall_cnt=1.
//  2 Same hazard, N=3 -> stall asserted exactly 3 consecutive cycles, then 0; stall_cnt=3.
//  3 N=3, PCSrcE=1 on 2nd stall cycle -> that cycle FlushD=FlushE=1, StallD=0; RUN next; flush_cnt=1.
//  4 RdM=RdW=7, both RegWrite, Rs1E=7 -> ForwardAE=10; RegWriteM=0 -> 01; Rs2E=0,RdM=0 -> ForwardBE=00.
//  5 lwHit with RdE=0 -> no stall; rst pulse during STALL -> all outputs 0, counters 0 next cycle.
//  6 Preload stall_cnt near all-ones (CNT_W=4), 20 stall cycles -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/hazard_if.sv
// Pipeline-register control bundle between the datapath (master) and hazard_ctrl (slave).
// Carries register IDs, write enables, stall/flush controls, forwarding selects and counters.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteE, RegWriteM, RegWriteW, PCSrcE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteE, RegWriteM, RegWriteW, PCSrcE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteE, RegWriteM, RegWriteW, PCSrcE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, taken-branch flush and EX-stage forwarding control for a 5-stage pipeline,
// with saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  typedef enum logic {RUN, STALL} state_e;

  localparam logic [3:0] BUB_INIT =
    (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

  state_e           state_q;
  logic [3:0]       bub_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             lw_hit;
  logic             hold;
  logic             flush_dec;
  logic             flush_ex;

  logic [4:0]       rs_e [2];
  logic [1:0]       fwd_sel [2];

  assign lw_hit = hz.RegWriteE && (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // A taken branch squashes whatever the stall logic wanted this cycle.
  always_comb begin
    hold      = 1'b0;
    flush_dec = 1'b0;
    flush_ex  = 1'b0;
    if (!rst) begin
      if (hz.PCSrcE) begin
        flush_dec = 1'b1;
        flush_ex  = 1'b1;
      end else if (state_q == STALL || lw_hit) begin
        hold     = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  assign rs_e[0] = hz.Rs1E;
  assign rs_e[1] = hz.Rs2E;

  // MEM has the younger value, so it wins over WB; x0 is never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (!rst) begin
          if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs_e[gi])
            fwd_sel[gi] = 2'b10;
          else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs_e[gi])
            fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      bub_q   <= 4'd0;
    end else if (hz.PCSrcE) begin
      state_q <= RUN;
      bub_q   <= 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (lw_hit && LOAD_STALL_CYCLES > 1) begin
            state_q <= STALL;
            bub_q   <= BUB_INIT;
          end
        end
        STALL: begin
          if (bub_q == 4'd0) state_q <= RUN;
          else               bub_q   <= bub_q - 4'd1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign stall_cnt_d = (hold && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (hz.PCSrcE && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallF    = hold;
  assign hz.StallD    = hold;
  assign hz.FlushD    = flush_dec;
  assign hz.FlushE    = flush_ex;
  assign hz.ForwardAE = fwd_sel[0];
  assign hz.ForwardBE = fwd_sel[1];
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
